// File: rtl/hazard_ctrl_if.sv
// Bundle of D/E/M/W hazard inputs and the stall/forward/MDU status outputs.
// The pipeline side drives through master; hazard_ctrl consumes through slave.
interface hazard_ctrl_if #(
  parameter int CNT_W = 16
);
  logic [4:0]       D_rs;
  logic [4:0]       D_rt;
  logic [1:0]       D_Tuse_rs;
  logic [1:0]       D_Tuse_rt;
  logic             D_md;
  logic [4:0]       E_RegWreg;
  logic             E_Regwrite;
  logic [1:0]       E_Tnew;
  logic [4:0]       M_RegWreg;
  logic             M_Regwrite;
  logic [1:0]       M_Tnew;
  logic [4:0]       W_RegWreg;
  logic             W_Regwrite;
  logic [1:0]       W_Tnew;
  logic             E_md_start;
  logic             E_md_div;
  logic             stall;
  logic [1:0]       fwd_rs_D;
  logic [1:0]       fwd_rt_D;
  logic             md_busy;
  logic             md_err;
  logic [CNT_W-1:0] stall_cnt;

  modport master (
    output D_rs, D_rt, D_Tuse_rs, D_Tuse_rt, D_md,
    output E_RegWreg, E_Regwrite, E_Tnew,
    output M_RegWreg, M_Regwrite, M_Tnew,
    output W_RegWreg, W_Regwrite, W_Tnew,
    output E_md_start, E_md_div,
    input  stall, fwd_rs_D, fwd_rt_D, md_busy, md_err, stall_cnt
  );

  modport slave (
    input  D_rs, D_rt, D_Tuse_rs, D_Tuse_rt, D_md,
    input  E_RegWreg, E_Regwrite, E_Tnew,
    input  M_RegWreg, M_Regwrite, M_Tnew,
    input  W_RegWreg, W_Regwrite, W_Tnew,
    input  E_md_start, E_md_div,
    output stall, fwd_rs_D, fwd_rt_D, md_busy, md_err, stall_cnt
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Central hazard controller for the 5-stage MIPS pipeline: Tuse/Tnew stall,
// D-stage forward selects, MDU busy countdown and a saturating stall counter.
module hazard_ctrl #(
  parameter int MULT_LAT = 5,
  parameter int DIV_LAT  = 10,
  parameter int CNT_W    = 16
) (
  input  logic          clk,
  input  logic          reset,
  hazard_ctrl_if.slave  hz
);
  localparam int MAX_LAT = (DIV_LAT > MULT_LAT) ? DIV_LAT : MULT_LAT;
  localparam int MD_W    = $clog2(MAX_LAT + 1);

  // Producer stages indexed youngest first: 0 = E, 1 = M, 2 = W.
  logic [4:0] st_reg  [0:2];
  logic       st_wr   [0:2];
  logic [1:0] st_tnew [0:2];

  assign st_reg[0]  = hz.E_RegWreg;
  assign st_reg[1]  = hz.M_RegWreg;
  assign st_reg[2]  = hz.W_RegWreg;
  assign st_wr[0]   = hz.E_Regwrite;
  assign st_wr[1]   = hz.M_Regwrite;
  assign st_wr[2]   = hz.W_Regwrite;
  assign st_tnew[0] = hz.E_Tnew;
  assign st_tnew[1] = hz.M_Tnew;
  assign st_tnew[2] = hz.W_Tnew;

  logic [2:0] hit_rs;
  logic [2:0] hit_rt;
  logic [2:0] late_rs;
  logic [2:0] late_rt;

  // Tuse=3 marks an unused source; a 2-bit Tnew can never exceed it, so no extra gate.
  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_stage
      assign hit_rs[gi]  = st_wr[gi] && (st_reg[gi] != 5'd0) && (st_reg[gi] == hz.D_rs);
      assign hit_rt[gi]  = st_wr[gi] && (st_reg[gi] != 5'd0) && (st_reg[gi] == hz.D_rt);
      assign late_rs[gi] = hit_rs[gi] && (st_tnew[gi] > hz.D_Tuse_rs);
      assign late_rt[gi] = hit_rt[gi] && (st_tnew[gi] > hz.D_Tuse_rt);
    end
  endgenerate

  logic [MD_W-1:0]  md_cnt_q,    md_cnt_d;
  logic             md_err_q,    md_err_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic             md_busy;
  logic             stall;
  logic [1:0]       fwd_rs;
  logic [1:0]       fwd_rt;

  always_comb begin
    md_busy = (md_cnt_q != '0);
    stall   = (|late_rs) || (|late_rt) || (hz.D_md && (md_busy || hz.E_md_start));
  end

  // Only the youngest matching producer may forward, and only once its value exists.
  always_comb begin
    fwd_rs = 2'd0;
    if (hit_rs[0])      fwd_rs = (st_tnew[0] == 2'd0) ? 2'd3 : 2'd0;
    else if (hit_rs[1]) fwd_rs = (st_tnew[1] == 2'd0) ? 2'd2 : 2'd0;
    else if (hit_rs[2]) fwd_rs = (st_tnew[2] == 2'd0) ? 2'd1 : 2'd0;

    fwd_rt = 2'd0;
    if (hit_rt[0])      fwd_rt = (st_tnew[0] == 2'd0) ? 2'd3 : 2'd0;
    else if (hit_rt[1]) fwd_rt = (st_tnew[1] == 2'd0) ? 2'd2 : 2'd0;
    else if (hit_rt[2]) fwd_rt = (st_tnew[2] == 2'd0) ? 2'd1 : 2'd0;
  end

  always_comb begin
    md_cnt_d = md_cnt_q;
    if (hz.E_md_start && !md_busy)
      md_cnt_d = hz.E_md_div ? MD_W'(DIV_LAT) : MD_W'(MULT_LAT);
    else if (md_cnt_q != '0)
      md_cnt_d = md_cnt_q - 1'b1;

    // A start while busy is dropped and latched as a sticky error.
    md_err_d = md_err_q || (hz.E_md_start && md_busy);

    stall_cnt_d = stall_cnt_q;
    if (stall && (stall_cnt_q != '1))
      stall_cnt_d = stall_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      md_cnt_q    <= '0;
      md_err_q    <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      md_cnt_q    <= md_cnt_d;
      md_err_q    <= md_err_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign hz.stall     = stall;
  assign hz.fwd_rs_D  = fwd_rs;
  assign hz.fwd_rt_D  = fwd_rt;
  assign hz.md_busy   = md_busy;
  assign hz.md_err    = md_err_q;
  assign hz.stall_cnt = stall_cnt_q;
endmodule
